mem_stage_lsu: RTL

- Memory-access stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM and MEM/WB pipeline registers.
- Converts load/store controls plus the ALU address into a req/gnt/rvalid data-memory transaction.
- Performs byte-lane steering, byte enables and load sign/zero extension.
- Stalls the pipeline until the access completes, then presents ReadData_M and a gated RegWrite to MEM/WB.

---
 rtl/riscv_lsu_pkg.sv | 49 ++++
 rtl/mem_stage_lsu_load_extend.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// ============================================================================
// Module      : riscv_lsu_pkg
// Description : Shared definitions for the MEM-stage load/store unit.
//               Holds the funct3 access-size codes, the LSU FSM state type,
//               the byte-enable patterns and a size-decode helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_lsu_pkg;

    // funct3 access size/sign codes (loads and stores share B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns; the byte pattern is shifted by the lane offset
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Undefined funct3 encodings fall into the word size
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_BYTE;
            F3_H, F3_HU: size_of = SZ_HALF;
            default:     size_of = SZ_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_load_extend.sv
// ============================================================================
// Module      : lsu_load_extend
// Description : Combinational load-data alignment and extension. Selects the
//               byte or halfword addressed by the captured offset and sign- or
//               zero-extends it; words and undefined encodings pass through.
// Ports       : i_rdata  - raw 32-bit word from data memory
//               i_offset - byte offset of the access within the word
//               i_funct3 - access size/sign code
//               o_ext    - aligned, extended 32-bit result
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_extend
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Only offset[1] matters for a halfword; bit 0 is never set on a
        // legal halfword access.
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ext = {24'b0, w_byte};
            F3_H:    o_ext = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ext = {16'b0, w_half};
            default: o_ext = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit of the 5-stage RISC-V pipeline.
//               Turns load/store controls and the ALU address into a
//               req/gnt/rvalid data-memory transaction, steers store bytes
//               onto lanes, extends load data and stalls the pipeline until
//               the access is complete.
// Ports       : clk, rst_n (async, active-low)
//               MemRead_M/MemWrite_M/funct3_M/addr_M/WriteData_M/RegWrite_M
//                   - EX/MEM controls and operands
//               RegWrite_MW/ReadData_M - to MEM/WB
//               stall_M     - freezes PC, IF/ID, ID/EX, EX/MEM
//               dmem_*      - data memory request/response interface
//               misaligned_M- misaligned access pulse
// Options     : MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//               accesses are not issued and pulse misaligned_M instead; when
//               undefined the offset bits below the access size are ignored.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead_M,
    input  logic                  MemWrite_M,
    input  logic [2:0]            funct3_M,
    input  logic [ADDR_WIDTH-1:0] addr_M,
    input  logic [DATA_WIDTH-1:0] WriteData_M,
    input  logic                  RegWrite_M,
    output logic                  RegWrite_MW,
    output logic [DATA_WIDTH-1:0] ReadData_M,
    output logic                  stall_M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  misaligned_M
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_offset;
    logic [2:0]            r_funct3;

    logic                  w_access;
    logic                  w_is_store;
    logic                  w_misaligned;
    logic                  w_req;
    logic                  w_stall;
    logic                  w_trap;
    lsu_size_t             w_size;
    logic [1:0]            w_offset;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_size     = size_of(funct3_M);
    assign w_access   = MemRead_M | MemWrite_M;
    // A simultaneous read+write request is handled as a store
    assign w_is_store = MemWrite_M;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (w_size)
            SZ_HALF: w_misaligned = addr_M[0];
            SZ_WORD: w_misaligned = |addr_M[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end
    // Misaligned accesses never reach grant, so the raw offset is safe
    assign w_offset = addr_M[1:0];
`else
    assign w_misaligned = 1'b0;
    always_comb begin
        case (w_size)
            SZ_HALF: w_offset = {addr_M[1], 1'b0};
            SZ_WORD: w_offset = 2'b00;
            default: w_offset = addr_M[1:0];
        endcase
    end
`endif

    // Store lane steering; loads always read the full word
    always_comb begin
        w_be    = BE_WORD;
        w_wdata = WriteData_M;
        if (w_is_store) begin
            case (w_size)
                SZ_BYTE: begin
                    w_be    = BE_BYTE << w_offset;
                    w_wdata = {4{WriteData_M[7:0]}};
                end
                SZ_HALF: begin
                    w_be    = w_offset[1] ? BE_HALF_HI : BE_HALF_LO;
                    w_wdata = {2{WriteData_M[15:0]}};
                end
                default: begin
                    w_be    = BE_WORD;
                    w_wdata = WriteData_M;
                end
            endcase
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_stall = 1'b0;
        w_trap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        w_trap = 1'b1;
                    end else begin
                        w_req   = 1'b1;
                        w_stall = 1'b1;
                        if (dmem_gnt) begin
                            w_next = w_is_store ? DONE : WAIT;
                        end else begin
                            w_next = REQ;
                        end
                    end
                end
            end
            REQ: begin
                // EX/MEM is frozen, so address and lane data stay stable
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem_gnt) begin
                    w_next = w_is_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (dmem_rvalid) begin
                    w_next = DONE;
                end
            end
            default: begin
                // DONE: the instruction advances into MEM/WB at this edge;
                // whatever enters M next is evaluated from IDLE.
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rdata  <= '0;
            r_offset <= '0;
            r_funct3 <= '0;
        end else begin
            r_state <= w_next;
            if (w_req && dmem_gnt) begin
                r_offset <= w_offset;
                r_funct3 <= funct3_M;
            end
            if ((r_state == WAIT) && dmem_rvalid) begin
                r_rdata <= w_ext;
            end
        end
    end

    lsu_load_extend u_load_extend (
        .i_rdata  (dmem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_ext    (w_ext)
    );

    assign dmem_req     = w_req;
    assign dmem_we      = w_req & w_is_store;
    assign dmem_addr    = {addr_M[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be      = w_be;
    assign dmem_wdata   = w_wdata;
    assign stall_M      = w_stall;
    assign misaligned_M = w_trap;
    assign ReadData_M   = r_rdata;
    // Stalled or trapped cycles hand a bubble to MEM/WB
    assign RegWrite_MW  = RegWrite_M & ~w_stall & ~w_trap;

endmodule

`default_nettype wire
